sqrt_share_ctrl: RTL and testbench
==================================

Name: sqrt_share_ctrl

Overview:
Round-robin arbiter and sequencer that shares one sequential square-root engine between NUM_REQ requesters. It accepts one operand at a time from the granted requester and issues it to the engine over a valid/ready handshake. It collects the engine result and returns it on a single tagged output channel with the requester ID. The engine is instantiated beside this block; this block owns only arbitration, sequencing and result buffering.

Parameters:
N, 16, operand width (even); result width is N/2
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), localparam, requester ID width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_num  in  NUM_REQ*N  packed operands; requester i at bits [i*N +: N]
req_vld  in  NUM_REQ  per-requester operand valid
req_rdy  out  NUM_REQ  per-requester accept; at most one bit high
eng_num  out  N  operand to engine
eng_num_vld  out  1  operand valid to engine
eng_num_rdy  in  1  engine ready for operand
eng_res  in  N/2  engine result
eng_res_vld  in  1  engine result valid (single-cycle pulse)
eng_res_rdy  out  1  controller ready for result
out_res  out  N/2  returned square root
out_id  out  ID_W  index of originating requester
out_vld  out  1  output valid
out_rdy  in  1  output consumer ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, all outputs 0 (req_rdy, eng_num, eng_num_vld, eng_res_rdy, out_res, out_id, out_vld, busy). Reset mid-operation aborts the transaction without returning a result. The engine is reset in the same cycle by the integrating level.
- States: IDLE, ISSUE, WAIT, CAPTURE, DELIVER.
- IDLE: grant g = first i with req_vld[i] set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_rdy[g] is combinational, asserted in the same cycle (zero-latency accept).
  - On that edge: op_reg<=req_num[g], id_reg<=g, go to ISSUE.
  - With no req_vld set: stay in IDLE, all req_rdy=0.
- Requester rule: hold req_num stable while req_vld is high and not yet accepted. The controller never drops a pending req_vld.
- ISSUE: eng_num=op_reg, eng_num_vld=1. On eng_num_vld & eng_num_rdy, go to WAIT. Stall indefinitely while eng_num_rdy=0.
- WAIT: eng_res_rdy=1, eng_num_vld=0. On eng_res_vld, go to CAPTURE. The engine registers its result on this handshake.
- CAPTURE (1 cycle): out_res<=eng_res, out_id<=id_reg, out_vld<=1, go to DELIVER.
- DELIVER: hold out_res, out_id and out_vld=1 until out_rdy. On out_vld & out_rdy: out_vld<=0, rr_ptr<=(id_reg+1) mod NUM_REQ, go to IDLE.
  - A new grant can occur in the following cycle.
  - out_rdy asserted before out_vld has no effect.
- Only one transaction is in flight. req_rdy is all-zero outside IDLE.
- Fairness: the granted requester has lowest priority for the next grant. No requester waits more than NUM_REQ-1 transactions.
- Throughput overhead: 4 controller cycles per transaction plus engine latency plus out_rdy stall.
- eng_res_vld outside WAIT is ignored (protocol error, no state change).
- Width rules: ID wraps from NUM_REQ-1 to 0. out_res is N/2 bits, unsigned floor sqrt.

Test Plan:
- Reset then single request: req_vld[2]=1, num=144 → req_rdy[2] pulses in the same cycle; eng_num=144 in ISSUE; out_res=12, out_id=2, out_vld held until out_rdy; busy=0 after.
- All four requesting simultaneously with nums 0, 1, 65535, 10000 from reset → grants in order 0,1,2,3; results 0, 1, 255, 100 with matching out_id.
- Round-robin fairness: req 1 and 3 continuously valid → grant sequence 1,3,1,3; never two consecutive grants to the same requester while the other is pending.
- Backpressure: out_rdy=0 for 20 cycles after out_vld → out_res/out_id stable, no req_rdy asserted, engine idle; release gives one accept then IDLE.
- Engine stall: eng_num_rdy held low 5 cycles → eng_num_vld and eng_num stay asserted/stable; transaction completes correctly afterward.
- Async reset asserted during WAIT → all outputs 0 immediately (no clock edge); after release, a new request num=49 returns 7 with rr_ptr restarting at 0.

Source files
------------

// File: rtl/sqrt_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one sequential square-root engine
// between NUM_REQ requesters; returns each result tagged with its requester ID.
module sqrt_share_ctrl #(
    parameter int N = 16,
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ*N-1:0]   req_num,
    input  logic [NUM_REQ-1:0]     req_vld,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic [N-1:0]           eng_num,
    output logic                   eng_num_vld,
    input  logic                   eng_num_rdy,
    input  logic [N/2-1:0]         eng_res,
    input  logic                   eng_res_vld,
    output logic                   eng_res_rdy,
    output logic [N/2-1:0]         out_res,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DELIVER
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [N-1:0]     op_q, op_d;
    logic [N/2-1:0]   out_res_q, out_res_d;
    logic             out_vld_q, out_vld_d;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    int               idx;

    // Search starts at rr_ptr so the previous winner is considered last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_vld && req_vld[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        out_res_d   = out_res_q;
        out_id_d    = out_id_q;
        out_vld_d   = out_vld_q;
        req_rdy     = '0;
        eng_num     = '0;
        eng_num_vld = 1'b0;
        eng_res_rdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Accept is combinational; masked during reset so outputs stay low.
                if (grant_vld && !reset) begin
                    req_rdy[grant_id] = 1'b1;
                    op_d    = req_num[int'(grant_id)*N +: N];
                    id_d    = grant_id;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_num     = op_q;
                eng_num_vld = 1'b1;
                if (eng_num_rdy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                eng_res_rdy = 1'b1;
                if (eng_res_vld) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_res_d = eng_res;
                out_id_d  = id_q;
                out_vld_d = 1'b1;
                state_d   = S_DELIVER;
            end
            S_DELIVER: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    rr_ptr_d  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            op_q      <= '0;
            out_res_q <= '0;
            out_id_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            out_res_q <= out_res_d;
            out_id_q  <= out_id_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out_res = out_res_q;
    assign out_id  = out_id_q;
    assign out_vld = out_vld_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Bench for sqrt_share_ctrl: behavioural engine, directed vector table,
// multi-cycle corner sequences and a randomized scoreboard run.
module tb_sqrt_share_ctrl;
    localparam int N = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ*N-1:0]  req_num = '0;
    logic [NUM_REQ-1:0]    req_vld = '0;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [N-1:0]          eng_num;
    logic                  eng_num_vld;
    logic                  eng_num_rdy;
    logic [N/2-1:0]        eng_res = '0;
    logic                  eng_res_vld = 1'b0;
    logic                  eng_res_rdy;
    logic [N/2-1:0]        out_res;
    logic [ID_W-1:0]       out_id;
    logic                  out_vld;
    logic                  out_rdy = 1'b0;
    logic                  busy;

    sqrt_share_ctrl #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset(reset), .req_num(req_num), .req_vld(req_vld),
        .req_rdy(req_rdy), .eng_num(eng_num), .eng_num_vld(eng_num_vld),
        .eng_num_rdy(eng_num_rdy), .eng_res(eng_res), .eng_res_vld(eng_res_vld),
        .eng_res_rdy(eng_res_rdy), .out_res(out_res), .out_id(out_id),
        .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural engine: accepts one operand, pulses floor-sqrt after eng_lat cycles.
    logic eng_busy = 1'b0;
    logic eng_rdy_en = 1'b1;
    int   eng_lat = 1;
    int   eng_cnt = 0;
    int   eng_op = 0;
    assign eng_num_rdy = eng_rdy_en && !eng_busy;

    always begin
        logic hs;
        int   op_s;
        @(negedge clk);
        hs   = eng_num_vld && eng_num_rdy;
        op_s = int'(eng_num);
        @(posedge clk);
        #1;
        if (reset) begin
            eng_busy = 1'b0; eng_res_vld = 1'b0; eng_cnt = 0;
        end else if (eng_res_vld) begin
            eng_res_vld = 1'b0; eng_busy = 1'b0;
        end else if (hs) begin
            eng_busy = 1'b1; eng_op = op_s; eng_cnt = eng_lat;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_res = 8'(isqrt(eng_op));
                eng_res_vld = 1'b1;
            end else begin
                eng_cnt--;
            end
        end
    end

    // Reference model state: pending operands per requester, expected outputs.
    int q[NUM_REQ][$];
    int sb_id[$];
    int sb_res[$];
    int got_id[$];
    int got_res[$];
    int m_ptr = 0;
    bit m_idle = 1'b1;

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += q[i].size();
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_rdy"}, req_rdy, 0);
        check({tag, "_eng_num"}, eng_num, 0);
        check({tag, "_eng_num_vld"}, eng_num_vld, 0);
        check({tag, "_eng_res_rdy"}, eng_res_rdy, 0);
        check({tag, "_out_res"}, out_res, 0);
        check({tag, "_out_id"}, out_id, 0);
        check({tag, "_out_vld"}, out_vld, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_vld = '0; req_num = '0; out_rdy = 1'b0; eng_rdy_en = 1'b1;
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0;
        m_idle = 1'b1;
    endtask

    // Waits (bounded) for out_vld, checks the tagged result, then hands it off.
    task automatic finish_out(input string nm, input int exp_res, input int exp_id);
        for (int c = 0; c < 100 && !out_vld; c++) tick();
        check({nm, "_out_vld"}, out_vld, 1);
        check({nm, "_out_res"}, out_res, exp_res);
        check({nm, "_out_id"}, out_id, exp_id);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check({nm, "_vld_clr"}, out_vld, 0);
    endtask

    task automatic do_single(input int id, input int num, input int exp_res);
        req_vld = '0;
        req_vld[id] = 1'b1;
        req_num = '0;
        req_num[id*N +: N] = N'(num);
        #1;
        check("acc_rdy", req_rdy, 32'(1) << id);
        tick();
        req_vld = '0;
        check("issue_num", eng_num, num);
        check("issue_vld", eng_num_vld, 1);
        check("busy_hi", busy, 1);
        finish_out("single", exp_res, id);
        check("busy_lo", busy, 0);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vld[i] = (q[i].size() > 0);
            req_num[i*N +: N] = (q[i].size() > 0) ? N'(q[i][0]) : '0;
        end
    endtask

    task automatic run_queue(input int cycles, input bit arrivals, input bit rand_ordy);
        logic [NUM_REQ-1:0] rdy, vld;
        logic ov, ordy;
        int oid, ores, eg, g, idx, eid, er;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rdy = req_rdy; vld = req_vld; ov = out_vld; ordy = out_rdy;
            oid = int'(out_id); ores = int'(out_res);
            if (m_idle) check("idle_accept", 32'(|rdy), 32'(|vld));
            if (rdy != 0) begin
                check("rdy_onehot", $countones(rdy), 1);
                eg = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (eg < 0 && vld[idx]) eg = idx;
                end
                g = $clog2(rdy);
                check("grant_id", g, eg);
                if (eg >= 0 && q[eg].size() > 0) begin
                    sb_id.push_back(eg);
                    sb_res.push_back(isqrt(q[eg].pop_front()));
                end
                m_idle = 1'b0;
            end
            if (ov && ordy) begin
                if (sb_id.size() == 0) begin
                    check("spurious_out", 32'(ov), 0);
                end else begin
                    eid = sb_id.pop_front();
                    er = sb_res.pop_front();
                    check("sb_out_id", oid, eid);
                    check("sb_out_res", ores, er);
                    got_id.push_back(oid);
                    got_res.push_back(ores);
                    m_ptr = (eid + 1) % NUM_REQ;
                    m_idle = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (arrivals) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (q[i].size() < 3 && $urandom_range(0, 3) == 0)
                        q[i].push_back(int'($urandom_range(0, 65535)));
            end
            drive_reqs();
            out_rdy = rand_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
            eng_lat = int'($urandom_range(0, 4));
            if (!arrivals && pending() == 0 && sb_id.size() == 0 && m_idle) break;
        end
        out_rdy = 1'b0;
    endtask

    typedef struct {
        int id;
        int num;
        int exp_res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ids[$];
        vecs[0] = '{2, 144, 12};
        vecs[1] = '{0, 0, 0};
        vecs[2] = '{1, 1, 1};
        vecs[3] = '{3, 65535, 255};
        vecs[4] = '{2, 10000, 100};
        vecs[5] = '{0, 49, 7};
        vecs[6] = '{3, 2, 1};
        vecs[7] = '{1, 15, 3};

        // Reset with a request pending: req_rdy must still read zero.
        req_vld = 4'b0100;
        #1;
        check_zero("por");
        do_reset();

        for (int v = 0; v < 8; v++) begin
            eng_lat = v % 3;
            do_single(vecs[v].id, vecs[v].num, vecs[v].exp_res);
        end

        // Output backpressure with another requester waiting.
        req_vld = 4'b0001; req_num = '0; req_num[0 +: N] = 16'd400;
        tick();
        req_vld = '0;
        for (int c = 0; c < 100 && !out_vld; c++) tick();
        req_vld = 4'b0100; req_num[2*N +: N] = 16'd81;
        out_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_out_vld", out_vld, 1);
            check("bp_out_res", out_res, 20);
            check("bp_out_id", out_id, 0);
            check("bp_req_rdy", req_rdy, 0);
            check("bp_eng_vld", eng_num_vld, 0);
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check("bp_release_vld", out_vld, 0);
        check("bp_next_accept", req_rdy, 4'b0100);
        tick();
        req_vld = '0;
        finish_out("bp_second", 9, 2);

        // Engine refuses the operand for 5 cycles.
        eng_rdy_en = 1'b0;
        req_vld = 4'b1000; req_num[3*N +: N] = 16'd625;
        tick();
        req_vld = '0;
        for (int c = 0; c < 5; c++) begin
            check("stall_vld", eng_num_vld, 1);
            check("stall_num", eng_num, 625);
            tick();
        end
        eng_rdy_en = 1'b1;
        finish_out("stall", 25, 3);

        // Move rr_ptr away from 0, then abort a transaction in WAIT.
        do_single(2, 900, 30);
        eng_lat = 20;
        req_vld = 4'b0010; req_num[1*N +: N] = 16'd100;
        tick();
        req_vld = '0;
        for (int c = 0; c < 10 && !eng_res_rdy; c++) tick();
        check("wait_reached", eng_res_rdy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async");
        eng_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        req_vld = 4'b1001;
        req_num[0 +: N] = 16'd49;
        req_num[3*N +: N] = 16'd64;
        #1;
        check("ptr_restart", req_rdy, 4'b0001);
        tick();
        req_vld = 4'b1000;
        finish_out("post_rst", 7, 0);
        tick();
        req_vld = '0;
        finish_out("post_rst2", 8, 3);

        // All four at once from reset.
        do_reset();
        got_id.delete(); got_res.delete();
        q[0].push_back(0); q[1].push_back(1); q[2].push_back(65535); q[3].push_back(10000);
        run_queue(400, 1'b0, 1'b1);
        check("all4_count", got_id.size(), 4);
        for (int k = 0; k < got_id.size() && k < 4; k++) check("all4_id", got_id[k], k);
        if (got_res.size() == 4) begin
            check("all4_res0", got_res[0], 0);
            check("all4_res1", got_res[1], 1);
            check("all4_res2", got_res[2], 255);
            check("all4_res3", got_res[3], 100);
        end

        // Requesters 1 and 3 continuously pending must alternate.
        got_id.delete(); got_res.delete();
        for (int k = 0; k < 3; k++) begin
            q[1].push_back(100 + k);
            q[3].push_back(2000 + k);
        end
        exp_ids = '{1, 3, 1, 3, 1, 3};
        run_queue(600, 1'b0, 1'b1);
        check("rr_count", got_id.size(), 6);
        for (int k = 0; k < got_id.size() && k < 6; k++) check("rr_seq", got_id[k], exp_ids[k]);

        // Randomized traffic against the scoreboard, then drain.
        do_reset();
        run_queue(3000, 1'b1, 1'b1);
        run_queue(1000, 1'b0, 1'b1);
        check("drain_pending", pending(), 0);
        check("drain_sb", sb_id.size(), 0);
        check("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
